rtc_sec_timer: RTL and testbench
================================

// Module: rtc_sec_timer
// PURPOSE
//  Downstream consumer of the timebase-correction stage. Each valid sample carries a corrected
//  30-bit sub-second count and a one-bit wrap flag. The block registers the sub-second value and
//  counts whole seconds on each wrap. It raises a seconds-compare interrupt and exposes everything
//  through a small 32-bit register port with a coherent SUB->SEC read snapshot.
// PARAMETERS
//  SUB_MAX   24000000  sub-second range; legal corrected values are 0..SUB_MAX-1
//  SUB_W     30        width of the corrected sub-second value
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  corr_valid  in   1   sample strobe from correction stage, one cycle per sample
//  corr_wrap   in   1   sample crossed a second boundary
//  corr_frac   in   30  corrected sub-second count
//  bus_addr    in   4   byte offset: 0x0 SUB(RO), 0x4 SEC, 0x8 CMP, 0xC CTRL
//  bus_wr      in   1   write strobe, single cycle
//  bus_rd      in   1   read strobe, single cycle
//  bus_wdata   in   32  write data
//  bus_rdata   out  32  read data, valid when bus_rvalid=1
//  bus_rvalid  out  1   read response, exactly 1 cycle after bus_rd
//  timer_irq   out  1   level interrupt = CTRL.pend & CTRL.irq_en
// BEHAVIOUR
//  - Reset (async assert, sync release): sub_q, sec_q, cmp_q, CTRL, shadow, shadow_vld,
//    bus_rdata, bus_rvalid, timer_irq all 0. CTRL.en=0 after reset.
//  - CTRL bits: [0] en, [1] irq_en, [2] pend (W1C), [3] range_err (sticky, W1C); [31:4] read 0.
//  - Samples are accepted only when CTRL.en=1 and corr_valid=1; otherwise ignored, no state change.
//    - sub_q <= corr_frac when corr_frac < SUB_MAX.
//    - Otherwise sub_q <= SUB_MAX-1 and range_err <= 1.
//    - When corr_wrap=1: sec_q <= sec_q+1, modulo 2^32 (0xFFFFFFFF -> 0).
//  - Compare:
//    - pend sets on the cycle after an accepted wrap makes sec_q+1 == cmp_q.
//    - A SEC or CMP write that makes them equal also sets pend.
//    - Equality while idle does not re-set pend once it is cleared.
//  - Writes:
//    - SEC and CMP take the full 32 bits.
//    - CTRL writes bits 0-1; a 1 in bit 2 or bit 3 clears that bit.
//    - A SUB write is ignored.
//  - Reads: 1-cycle latency; bus_rdata holds its value until the next read response.
//    SUB reads return {2'b0, sub_q}.
//  - Snapshot:
//    - A SUB read loads shadow <= sec_q and sets shadow_vld.
//    - The next SEC read returns shadow and clears shadow_vld.
//    - A SEC read with shadow_vld=0 returns live sec_q.
//    - A SEC write clears shadow_vld.
//  - Simultaneous events:
//    - SEC write + accepted wrap: the write wins (sec_q = wdata).
//    - pend set + pend W1C: set wins.
//    - range_err set + W1C: set wins.
//    - bus_rd + bus_wr on the same address: the write happens; the read returns the pre-write value.
//  - Reset mid-operation discards in-flight read responses (bus_rvalid drops to 0 immediately).
// STRUCTURE
//  - Shared package:
//    - register offsets ADDR_SUB/SEC/CMP/CTRL and CTRL bit indices;
//    - SUB_MAX constant, shared with the correction stage so both agree on the range.
//  - One sub-module, rtc_sec_regs: bus decode, CTRL/CMP storage, read mux, snapshot.
//    The top level keeps sub_q/sec_q, sample accept and compare logic.
// TESTING
//  1. Reset: hold rst_n=0 mid-stream -> every output and register reads 0, timer_irq=0.
//  2. CTRL.en=1, corr_valid with frac=1234, wrap=0 -> SUB read returns 1234 one cycle after rd;
//     SEC unchanged at 0.
//  3. SEC=0xFFFFFFFF, accepted wrap -> SEC reads 0; pend stays 0 with CMP=5.
//  4. Compare: SEC=4, CMP=5, irq_en=1, wrap -> pend=1 and timer_irq=1 next cycle.
//     W1C bit2 -> irq=0. W1C coinciding with a new match -> pend stays 1.
//  5. Snapshot: SEC=7, read SUB, then accepted wrap -> SEC read returns 7;
//     a second SEC read returns 8.
//  6. Range: corr_frac=24000000 -> SUB reads 23999999, CTRL[3]=1.
//     corr_valid with CTRL.en=0 -> no change.

Source files
------------

// File: rtl/rtc_sec_timer_pkg.sv
// Seconds timer shared definitions: register map, CTRL bits,
// and the sub-second range agreed with the correction stage.
package rtc_sec_timer_pkg;

    localparam int SUB_MAX = 24000000;
    localparam int SUB_W   = 30;

    localparam logic [3:0] ADDR_SUB  = 4'h0;
    localparam logic [3:0] ADDR_SEC  = 4'h4;
    localparam logic [3:0] ADDR_CMP  = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PEND   = 2;
    localparam int CTRL_RERR   = 3;

endpackage

// File: rtl/rtc_sec_timer_if.sv
// Register port of the seconds timer: single-cycle strobes,
// read data returned one cycle after the read strobe.
interface rtc_sec_timer_if;

    logic [3:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wdata,
        output bus_rdata, bus_rvalid
    );

endinterface

// File: rtl/rtc_sec_regs.sv
// Register block: bus decode, CTRL/CMP storage, read mux and
// the SUB->SEC coherent read snapshot.
module rtc_sec_regs
    import rtc_sec_timer_pkg::*;
#(
    parameter int SW = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    rtc_sec_timer_if.slave bus,
    input  logic [SW-1:0] sub_q,
    input  logic [31:0]   sec_q,
    input  logic          pend_set,
    input  logic          range_set,
    output logic          en,
    output logic          irq_en,
    output logic          pend,
    output logic [31:0]   cmp_q,
    output logic          sec_wr,
    output logic          cmp_wr,
    output logic [31:0]   wdata
);

    logic        ctrl_wr;
    logic        range_err;
    logic [31:0] shadow;
    logic        shadow_vld;
    logic [31:0] rd_mux;
    logic [31:0] sub_ext;

    assign wdata   = bus.bus_wdata;
    assign sec_wr  = bus.bus_wr && (bus.bus_addr == ADDR_SEC);
    assign cmp_wr  = bus.bus_wr && (bus.bus_addr == ADDR_CMP);
    assign ctrl_wr = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);
    assign sub_ext = {{(32-SW){1'b0}}, sub_q};

    // CTRL: plain enables, pend/range_err with set winning over W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            irq_en    <= 1'b0;
            pend      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en     <= wdata[CTRL_EN];
                irq_en <= wdata[CTRL_IRQ_EN];
            end
            pend <= pend_set ||
                    (pend && !(ctrl_wr && wdata[CTRL_PEND]));
            range_err <= range_set ||
                    (range_err && !(ctrl_wr && wdata[CTRL_RERR]));
        end
    end

    // Compare register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= '0;
        end else if (cmp_wr) begin
            cmp_q <= wdata;
        end
    end

    // Read mux sees pre-write state; SEC prefers a pending snapshot
    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_SUB:  rd_mux = sub_ext;
            ADDR_SEC:  rd_mux = shadow_vld ? shadow : sec_q;
            ADDR_CMP:  rd_mux = cmp_q;
            ADDR_CTRL: rd_mux = {28'b0, range_err, pend, irq_en, en};
            default:   rd_mux = '0;
        endcase
    end

    // Read response and snapshot bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_rdata  <= '0;
            bus.bus_rvalid <= 1'b0;
            shadow         <= '0;
            shadow_vld     <= 1'b0;
        end else begin
            bus.bus_rvalid <= bus.bus_rd;
            if (bus.bus_rd) begin
                bus.bus_rdata <= rd_mux;
            end
            if (bus.bus_rd && bus.bus_addr == ADDR_SUB) begin
                shadow     <= sec_q;
                shadow_vld <= 1'b1;
            end else if (sec_wr ||
                         (bus.bus_rd && bus.bus_addr == ADDR_SEC)) begin
                shadow_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_sec_timer.sv
// Seconds timer: registers corrected sub-second samples, counts
// seconds on wrap, raises a seconds-compare interrupt.
module rtc_sec_timer #(
    parameter int SUB_MAX = rtc_sec_timer_pkg::SUB_MAX,
    parameter int SUB_W   = rtc_sec_timer_pkg::SUB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             corr_valid,
    input  logic             corr_wrap,
    input  logic [SUB_W-1:0] corr_frac,
    rtc_sec_timer_if.slave   bus,
    output logic             timer_irq
);

    localparam logic [SUB_W-1:0] SUB_LIM  = SUB_W'(SUB_MAX);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_MAX - 1);

    logic [SUB_W-1:0] sub_q;
    logic [31:0]      sec_q;
    logic [31:0]      sec_next;
    logic [31:0]      cmp_next;
    logic [31:0]      cmp_q;
    logic [31:0]      wdata;
    logic             en;
    logic             irq_en;
    logic             pend;
    logic             sec_wr;
    logic             cmp_wr;
    logic             acc;
    logic             wrap_acc;
    logic             in_range;
    logic             pend_set;
    logic             range_set;

    assign acc       = en && corr_valid;
    assign wrap_acc  = acc && corr_wrap;
    assign in_range  = corr_frac < SUB_LIM;
    assign range_set = acc && !in_range;

    // A bus write to SEC overrides a concurrent wrap
    assign sec_next = sec_wr   ? wdata :
                      wrap_acc ? sec_q + 32'd1 : sec_q;
    assign cmp_next = cmp_wr ? wdata : cmp_q;

    // Match only counts when SEC or CMP actually changes this cycle
    assign pend_set = (sec_wr || cmp_wr || wrap_acc) &&
                      (sec_next == cmp_next);

    assign timer_irq = pend && irq_en;

    // Sub-second and seconds state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
            sec_q <= '0;
        end else begin
            if (acc) begin
                sub_q <= in_range ? corr_frac : SUB_LAST;
            end
            sec_q <= sec_next;
        end
    end

    rtc_sec_regs #(
        .SW(SUB_W)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sub_q     (sub_q),
        .sec_q     (sec_q),
        .pend_set  (pend_set),
        .range_set (range_set),
        .en        (en),
        .irq_en    (irq_en),
        .pend      (pend),
        .cmp_q     (cmp_q),
        .sec_wr    (sec_wr),
        .cmp_wr    (cmp_wr),
        .wdata     (wdata)
    );

endmodule

// File: tb/tb_rtc_sec_timer.sv
// Directed bench for rtc_sec_timer: read responses are checked
// against a scoreboard queue by a separate monitor.
module tb_rtc_sec_timer;

    logic        clk;
    logic        rst_n;
    logic        corr_valid;
    logic        corr_wrap;
    logic [29:0] corr_frac;
    logic        timer_irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    rtc_sec_timer_if bus();

    rtc_sec_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .corr_valid (corr_valid),
        .corr_wrap  (corr_wrap),
        .corr_frac  (corr_frac),
        .bus        (bus),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every read response pops one expected value
    always @(negedge clk) begin
        if (rst_n && bus.bus_rvalid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rvalid: got %h required none",
                         bus.bus_rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.bus_rdata !== e) begin
                    fails++;
                    $display("FAIL %s: got %h required %h",
                             n, bus.bus_rdata, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] e);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got %h required %h", n, got, e);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_wr    = 1'b1;
        @(posedge clk); #1;
        bus.bus_wr    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e,
                      input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.bus_addr = a;
        bus.bus_rd   = 1'b1;
        @(posedge clk); #1;
        bus.bus_rd   = 1'b0;
    endtask

    task automatic smp(input logic w, input logic [29:0] f);
        corr_valid = 1'b1;
        corr_wrap  = w;
        corr_frac  = f;
        @(posedge clk); #1;
        corr_valid = 1'b0;
        corr_wrap  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        corr_valid    = 1'b0;
        corr_wrap     = 1'b0;
        corr_frac     = '0;
        bus.bus_addr  = '0;
        bus.bus_wr    = 1'b0;
        bus.bus_rd    = 1'b0;
        bus.bus_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'b0, timer_irq}, 32'd0);
        chk("rst_rvalid", {31'b0, bus.bus_rvalid}, 32'd0);
        chk("rst_rdata", bus.bus_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(4'h0, 32'd0, "rst_sub");
        rd(4'h4, 32'd0, "rst_sec");
        rd(4'h8, 32'd0, "rst_cmp");
        rd(4'hC, 32'd0, "rst_ctrl");

        // Basic sample
        wr(4'hC, 32'h1);
        smp(1'b0, 30'd1234);
        rd(4'h0, 32'd1234, "sub_1234");
        rd(4'h4, 32'd0, "sec_nowrap");

        // Seconds wrap modulo 2^32
        wr(4'h8, 32'd5);
        wr(4'h4, 32'hFFFF_FFFF);
        smp(1'b1, 30'd10);
        rd(4'h4, 32'd0, "sec_rollover");
        rd(4'hC, 32'h1, "ctrl_no_pend");

        // Compare, W1C, set-wins, idle equality
        wr(4'h4, 32'd4);
        wr(4'hC, 32'h3);
        smp(1'b1, 30'd20);
        chk("irq_on_match", {31'b0, timer_irq}, 32'd1);
        rd(4'hC, 32'h7, "ctrl_pend");
        wr(4'hC, 32'h7);
        chk("irq_after_w1c", {31'b0, timer_irq}, 32'd0);
        wr(4'h4, 32'd4);
        bus.bus_addr  = 4'hC;
        bus.bus_wdata = 32'h7;
        bus.bus_wr    = 1'b1;
        corr_valid    = 1'b1;
        corr_wrap     = 1'b1;
        corr_frac     = 30'd30;
        @(posedge clk); #1;
        bus.bus_wr    = 1'b0;
        corr_valid    = 1'b0;
        corr_wrap     = 1'b0;
        chk("irq_set_wins", {31'b0, timer_irq}, 32'd1);
        rd(4'hC, 32'h7, "ctrl_set_wins");
        wr(4'hC, 32'h7);
        repeat (3) @(posedge clk);
        #1;
        rd(4'hC, 32'h3, "ctrl_idle_eq");
        chk("irq_idle_eq", {31'b0, timer_irq}, 32'd0);

        // Snapshot
        wr(4'h4, 32'd7);
        rd(4'h0, 32'd30, "snap_sub");
        smp(1'b1, 30'd200);
        rd(4'h4, 32'd7, "snap_sec");
        rd(4'h4, 32'd8, "live_sec");
        rd(4'h0, 32'd200, "sub_200");

        // Range clamp and disabled sampling
        smp(1'b0, 30'd24000000);
        rd(4'h0, 32'd23999999, "sub_clamp");
        rd(4'hC, 32'hB, "ctrl_rerr");
        wr(4'hC, 32'h8);
        rd(4'hC, 32'h0, "ctrl_cleared");
        smp(1'b1, 30'd50);
        rd(4'h0, 32'd23999999, "sub_disabled");
        rd(4'h4, 32'd8, "sec_disabled");
        wr(4'h0, 32'h123);
        rd(4'h0, 32'd23999999, "sub_wr_ignored");

        // Read and write to the same address together
        exp_q.push_back(32'd5);
        name_q.push_back("cmp_rw_old");
        bus.bus_addr  = 4'h8;
        bus.bus_wdata = 32'd9;
        bus.bus_wr    = 1'b1;
        bus.bus_rd    = 1'b1;
        @(posedge clk); #1;
        bus.bus_wr    = 1'b0;
        bus.bus_rd    = 1'b0;
        rd(4'h8, 32'd9, "cmp_rw_new");

        // Reset in the middle of a read response
        wr(4'hC, 32'h3);
        wr(4'h8, 32'd8);
        chk("irq_cmp_write", {31'b0, timer_irq}, 32'd1);
        bus.bus_addr = 4'h4;
        bus.bus_rd   = 1'b1;
        @(posedge clk); #1;
        bus.bus_rd   = 1'b0;
        chk("inflight_rvalid", {31'b0, bus.bus_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'b0, bus.bus_rvalid}, 32'd0);
        chk("mid_rst_rdata", bus.bus_rdata, 32'd0);
        chk("mid_rst_irq", {31'b0, timer_irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(4'h0, 32'd0, "mid_rst_sub");
        rd(4'h4, 32'd0, "mid_rst_sec");
        rd(4'h8, 32'd0, "mid_rst_cmp");
        rd(4'hC, 32'd0, "mid_rst_ctrl");

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_rvalid: got %0d pending required 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
